// File: rtl/lsu_memstage.sv
// rtl/lsu_memstage.sv - load/store unit for the memory-access pipeline stage
module lsu_memstage #(
    parameter int         XLEN           = 32,
    parameter int         STRB_W         = XLEN / 8,
    parameter int         TIMEOUT_CYCLES = 255,
    parameter logic [4:0] OP_LOAD        = 5'd1,
    parameter logic [4:0] OP_STORE       = 5'd2
) (
    input  logic              clk,
    input  logic              rstf,
    input  logic [31:0]       t_instr,
    input  logic              t_instr_valid,
    output logic              t_instr_ready,
    input  logic [XLEN-1:0]   iPC,
    input  logic [4:0]        iDecodedOP,
    input  logic [XLEN-1:0]   aluValue,
    input  logic [XLEN-1:0]   rs2Value,
    output logic [31:0]       i_instr,
    output logic              i_instr_valid,
    input  logic              i_instr_ready,
    output logic [XLEN-1:0]   oPC,
    output logic [4:0]        oDecodedOP,
    output logic [XLEN-1:0]   maAluValue,
    output logic [1:0]        oFault,
    output logic [XLEN-1:0]   dbus_cmd_addr,
    output logic [XLEN-1:0]   dbus_cmd_data,
    output logic              dbus_cmd_we,
    output logic [STRB_W-1:0] dbus_cmd_size,
    output logic              dbus_cmd_valid,
    input  logic              dbus_cmd_ready,
    input  logic [XLEN-1:0]   dbus_rsp_data,
    input  logic              dbus_rsp_valid
);

    localparam int          OFF_W    = $clog2(STRB_W);
    localparam logic [31:0] TO_LIMIT = TIMEOUT_CYCLES;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_RSP  = 2'd2;

    localparam logic [1:0] F_NONE   = 2'b00;
    localparam logic [1:0] F_MIS_LD = 2'b01;
    localparam logic [1:0] F_MIS_ST = 2'b10;
    localparam logic [1:0] F_TMO    = 2'b11;

    // Access size code from funct3: 0=byte 1=half 2=word 3=dword.
    // D and WU only exist on 64-bit datapaths; on 32-bit they act as W.
    function automatic logic [1:0] f_size(input logic [2:0] f3);
        if (XLEN == 32 && f3[1:0] == 2'b11) begin
            return 2'b10;
        end
        return f3[1:0];
    endfunction

    function automatic logic f_unsigned(input logic [2:0] f3);
        return f3[2] && (XLEN == 64 || !f3[1]);
    endfunction

    function automatic logic f_misaligned(input logic [1:0] size, input logic [2:0] addr);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return addr[0];
            2'd2:    return |addr[1:0];
            default: return |addr[2:0];
        endcase
    endfunction

    function automatic logic [7:0] f_size_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    logic [1:0]        r_state;
    logic              r_alive;
    logic              r_drop;
    logic [31:0]       r_cnt;
    logic [31:0]       r_instr;
    logic [XLEN-1:0]   r_pc;
    logic [4:0]        r_op;
    logic [XLEN-1:0]   r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [STRB_W-1:0] r_strb;
    logic              r_we;
    logic [31:0]       r_out_instr;
    logic              r_out_valid;
    logic [XLEN-1:0]   r_out_pc;
    logic [4:0]        r_out_op;
    logic [XLEN-1:0]   r_out_val;
    logic [1:0]        r_out_fault;

    logic              w_out_free;
    logic              w_in_ready;
    logic              w_accept;
    logic [1:0]        w_in_size;
    logic              w_in_is_ld;
    logic              w_in_is_st;
    logic              w_in_mem;
    logic              w_in_mis;
    logic [OFF_W-1:0]  w_in_off;
    logic [7:0]        w_in_base;
    logic [STRB_W-1:0] w_in_strb;
    logic [XLEN-1:0]   w_in_wdata;

    logic [1:0]        w_r_size;
    logic              w_r_uns;
    logic [OFF_W-1:0]  w_r_off;
    logic [XLEN-1:0]   w_rsp_shifted;
    logic [XLEN-1:0]   w_rsp_mask;
    logic              w_rsp_sign;
    logic [XLEN-1:0]   w_load_fmt;

    logic [1:0]        w_state_nxt;
    logic [31:0]       w_cnt_nxt;
    logic              w_drop_nxt;
    logic              w_wr;
    logic              w_wr_from_in;
    logic [XLEN-1:0]   w_wr_val;
    logic [1:0]        w_wr_fault;

    // The output register only accepts new data when empty or draining this cycle.
    // Accept also requires it, so the register is always empty while in CMD or RSP.
    assign w_out_free    = !r_out_valid || i_instr_ready;
    assign w_in_ready    = r_alive && (r_state == S_IDLE) && w_out_free;
    assign w_accept      = t_instr_valid && w_in_ready;
    assign t_instr_ready = w_in_ready;

    assign w_in_size  = f_size(t_instr[14:12]);
    assign w_in_is_ld = (iDecodedOP == OP_LOAD);
    assign w_in_is_st = (iDecodedOP == OP_STORE);
    assign w_in_mem   = w_in_is_ld || w_in_is_st;
    assign w_in_mis   = w_in_mem && f_misaligned(w_in_size, aluValue[2:0]);
    assign w_in_off   = aluValue[OFF_W-1:0];
    assign w_in_base  = f_size_mask(w_in_size);
    assign w_in_strb  = w_in_base[STRB_W-1:0] << w_in_off;
    assign w_in_wdata = rs2Value << {w_in_off, 3'b000};

    // Load formatting works from the captured instruction and address.
    assign w_r_size      = f_size(r_instr[14:12]);
    assign w_r_uns       = f_unsigned(r_instr[14:12]);
    assign w_r_off       = r_addr[OFF_W-1:0];
    assign w_rsp_shifted = dbus_rsp_data >> {w_r_off, 3'b000};

    // Extract the accessed bytes and sign- or zero-extend them to XLEN.
    always_comb begin
        w_rsp_mask = '1;
        w_rsp_sign = 1'b0;
        case (w_r_size)
            2'd0: begin
                w_rsp_mask = XLEN'(8'hFF);
                w_rsp_sign = w_rsp_shifted[7];
            end
            2'd1: begin
                w_rsp_mask = XLEN'(16'hFFFF);
                w_rsp_sign = w_rsp_shifted[15];
            end
            2'd2: begin
                w_rsp_mask = XLEN'(32'hFFFF_FFFF);
                w_rsp_sign = w_rsp_shifted[31];
            end
            default: begin
                w_rsp_mask = '1;
                w_rsp_sign = w_rsp_shifted[XLEN-1];
            end
        endcase
        w_load_fmt = (w_rsp_shifted & w_rsp_mask) |
                     ((w_rsp_sign && !w_r_uns) ? ~w_rsp_mask : '0);
    end

    // Next-state, timeout counter, response drop and result selection.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_drop_nxt   = r_drop;
        w_wr         = 1'b0;
        w_wr_from_in = 1'b0;
        w_wr_val     = r_addr;
        w_wr_fault   = F_NONE;
        if (dbus_rsp_valid && r_drop) begin
            w_drop_nxt = 1'b0;
        end
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_in_mem && !w_in_mis) begin
                        w_state_nxt = S_CMD;
                    end else begin
                        w_wr         = 1'b1;
                        w_wr_from_in = 1'b1;
                        w_wr_val     = aluValue;
                        if (w_in_mis) begin
                            w_wr_fault = w_in_is_ld ? F_MIS_LD : F_MIS_ST;
                        end
                    end
                end
            end
            S_CMD: begin
                if (dbus_cmd_ready) begin
                    if (r_we) begin
                        w_wr        = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_RSP;
                    end
                end
            end
            S_RSP: begin
                w_cnt_nxt = r_cnt + 32'd1;
                if (dbus_rsp_valid && !r_drop) begin
                    w_wr        = 1'b1;
                    w_wr_val    = w_load_fmt;
                    w_state_nxt = S_IDLE;
                end else if (TIMEOUT_CYCLES != 0 && w_cnt_nxt == TO_LIMIT) begin
                    // The lost response may still show up later; swallow it then.
                    w_wr        = 1'b1;
                    w_wr_fault  = F_TMO;
                    w_drop_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Control state; r_alive keeps t_instr_ready low until the first clock after reset.
    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            r_state <= S_IDLE;
            r_alive <= 1'b0;
            r_drop  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_alive <= 1'b1;
            r_drop  <= w_drop_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Capture the instruction and the bus command fields at accept.
    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            r_instr <= '0;
            r_pc    <= '0;
            r_op    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_strb  <= '0;
            r_we    <= 1'b0;
        end else if (w_accept) begin
            r_instr <= t_instr;
            r_pc    <= iPC;
            r_op    <= iDecodedOP;
            r_addr  <= aluValue;
            r_wdata <= w_in_wdata;
            r_strb  <= w_in_strb;
            r_we    <= w_in_is_st;
        end
    end

    // Output register toward writeback: load on a result, clear on a plain drain.
    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            r_out_instr <= '0;
            r_out_valid <= 1'b0;
            r_out_pc    <= '0;
            r_out_op    <= '0;
            r_out_val   <= '0;
            r_out_fault <= F_NONE;
        end else if (w_wr) begin
            r_out_valid <= 1'b1;
            r_out_instr <= w_wr_from_in ? t_instr    : r_instr;
            r_out_pc    <= w_wr_from_in ? iPC        : r_pc;
            r_out_op    <= w_wr_from_in ? iDecodedOP : r_op;
            r_out_val   <= w_wr_val;
            r_out_fault <= w_wr_fault;
        end else if (i_instr_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign i_instr        = r_out_instr;
    assign i_instr_valid  = r_out_valid;
    assign oPC            = r_out_pc;
    assign oDecodedOP     = r_out_op;
    assign maAluValue     = r_out_val;
    assign oFault         = r_out_fault;

    assign dbus_cmd_addr  = r_addr;
    assign dbus_cmd_data  = r_wdata;
    assign dbus_cmd_we    = r_we;
    assign dbus_cmd_size  = r_strb;
    assign dbus_cmd_valid = (r_state == S_CMD);

endmodule

// File: tb/tb_lsu_memstage.sv
// tb/tb_lsu_memstage.sv - self-checking bench for lsu_memstage
module tb_lsu_memstage;

    localparam int         T      = 4;
    localparam logic [4:0] OP_ALU = 5'd0;
    localparam logic [4:0] OP_LD  = 5'd1;
    localparam logic [4:0] OP_ST  = 5'd2;

    logic        clk = 1'b0;
    logic        rstf = 1'b1;
    logic [31:0] t_instr = '0;
    logic        t_instr_valid = 1'b0;
    logic        t_instr_ready;
    logic [31:0] iPC = '0;
    logic [4:0]  iDecodedOP = '0;
    logic [31:0] aluValue = '0;
    logic [31:0] rs2Value = '0;
    logic [31:0] i_instr;
    logic        i_instr_valid;
    logic        i_instr_ready = 1'b1;
    logic [31:0] oPC;
    logic [4:0]  oDecodedOP;
    logic [31:0] maAluValue;
    logic [1:0]  oFault;
    logic [31:0] dbus_cmd_addr;
    logic [31:0] dbus_cmd_data;
    logic        dbus_cmd_we;
    logic [3:0]  dbus_cmd_size;
    logic        dbus_cmd_valid;
    logic        dbus_cmd_ready = 1'b0;
    logic [31:0] dbus_rsp_data = '0;
    logic        dbus_rsp_valid = 1'b0;

    always #5 clk = ~clk;

    lsu_memstage #(
        .XLEN(32), .STRB_W(4), .TIMEOUT_CYCLES(T), .OP_LOAD(OP_LD), .OP_STORE(OP_ST)
    ) dut (
        .clk(clk), .rstf(rstf),
        .t_instr(t_instr), .t_instr_valid(t_instr_valid), .t_instr_ready(t_instr_ready),
        .iPC(iPC), .iDecodedOP(iDecodedOP), .aluValue(aluValue), .rs2Value(rs2Value),
        .i_instr(i_instr), .i_instr_valid(i_instr_valid), .i_instr_ready(i_instr_ready),
        .oPC(oPC), .oDecodedOP(oDecodedOP), .maAluValue(maAluValue), .oFault(oFault),
        .dbus_cmd_addr(dbus_cmd_addr), .dbus_cmd_data(dbus_cmd_data), .dbus_cmd_we(dbus_cmd_we),
        .dbus_cmd_size(dbus_cmd_size), .dbus_cmd_valid(dbus_cmd_valid), .dbus_cmd_ready(dbus_cmd_ready),
        .dbus_rsp_data(dbus_rsp_data), .dbus_rsp_valid(dbus_rsp_valid)
    );

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rsp;
        int          cmd_dly;
        int          rsp_dly;
        logic [1:0]  fault;
        logic [31:0] val;
        bit          cmd;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0]  obs_fault;
    logic [31:0] obs_val;
    bit          obs_cmd;
    logic [3:0]  obs_strb;
    logic [31:0] obs_wdata;
    logic        obs_we;
    logic [31:0] obs_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: size/sign from funct3, alignment by modulo, lanes by byte offset.
    function automatic void model(input logic [4:0] op, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] rsp,
                                  output logic [1:0] fault, output logic [31:0] val, output bit cmd,
                                  output logic [3:0] strb, output logic [31:0] wdata);
        int     nb;
        int     off;
        longint v;
        longint lim;
        bit     sgn;
        bit     mem;
        nb  = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        sgn = !(f3 == 3'd4 || f3 == 3'd5);
        mem = (op == OP_LD) || (op == OP_ST);
        off = int'(addr[1:0]);
        fault = 2'd0; val = addr; cmd = 1'b0; strb = 4'd0; wdata = 32'd0;
        if (mem && (addr % 32'(nb)) != 32'd0) begin
            fault = (op == OP_LD) ? 2'd1 : 2'd2;
        end else if (mem) begin
            cmd   = 1'b1;
            strb  = 4'(((32'd1 << nb) - 32'd1) << off);
            wdata = rs2 << (8 * off);
            if (op == OP_LD) begin
                lim = longint'(1) << (8 * nb);
                v   = longint'(rsp >> (8 * off)) % lim;
                if (sgn && v >= lim / 2) v = v - lim;
                val = 32'(v);
            end
        end
    endfunction

    // Push one instruction, act as the data bus, and record what completes.
    task automatic run_op(input logic [4:0] op, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [31:0] rsp,
                          input int cmd_dly, input int rsp_dly, input bit no_rsp, input bit late_pulse);
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] o_instr;
        logic [31:0] o_pc;
        logic [4:0]  o_op;
        int cyc, wc, rc, hs_cyc, rsp_cyc, exp_lat;
        bit hs, hs_now, got, stable;
        instr = ($urandom & 32'hFFFF_8FFF) | (32'(f3) << 12);
        pc    = $urandom;
        t_instr = instr; iPC = pc; iDecodedOP = op; aluValue = addr; rs2Value = rs2;
        t_instr_valid = 1'b1;
        wc = 0;
        while (!t_instr_ready && wc < 20) begin
            @(posedge clk); #1; wc++;
        end
        chk("accept_ready", 64'(t_instr_ready), 64'd1);
        @(posedge clk); #1;
        t_instr_valid = 1'b0;
        t_instr = $urandom; iPC = $urandom; aluValue = $urandom; rs2Value = $urandom;
        iDecodedOP = 5'($urandom_range(0, 2));
        cyc = 0; wc = 0; rc = 0; hs = 1'b0; got = 1'b0; stable = 1'b1;
        hs_cyc = -1; rsp_cyc = -1; obs_cmd = 1'b0; obs_we = 1'b0;
        o_instr = '0; o_pc = '0; o_op = '0;
        while (!got && cyc < 60) begin
            dbus_cmd_ready = 1'b0; dbus_rsp_valid = 1'b0; dbus_rsp_data = $urandom; hs_now = 1'b0;
            if (i_instr_valid) begin
                got = 1'b1;
                obs_fault = oFault; obs_val = maAluValue;
                o_instr = i_instr; o_pc = oPC; o_op = oDecodedOP;
            end else begin
                if (dbus_cmd_valid && !hs) begin
                    if (!obs_cmd) begin
                        obs_cmd = 1'b1; obs_strb = dbus_cmd_size; obs_wdata = dbus_cmd_data;
                        obs_we = dbus_cmd_we; obs_addr = dbus_cmd_addr;
                    end else if ({dbus_cmd_size, dbus_cmd_data, dbus_cmd_we, dbus_cmd_addr} !==
                                 {obs_strb, obs_wdata, obs_we, obs_addr}) begin
                        stable = 1'b0;
                    end
                    if (wc == cmd_dly) begin
                        dbus_cmd_ready = 1'b1; hs_now = 1'b1; hs_cyc = cyc;
                    end
                    wc++;
                end else if (hs && !obs_we) begin
                    if (late_pulse && rc == 0) begin
                        dbus_rsp_valid = 1'b1; dbus_rsp_data = ~rsp;
                    end
                    if (!no_rsp && rc == rsp_dly) begin
                        dbus_rsp_valid = 1'b1; dbus_rsp_data = rsp; rsp_cyc = cyc;
                    end
                    rc++;
                end
                @(posedge clk); #1;
                if (hs_now) hs = 1'b1;
                cyc++;
            end
        end
        dbus_cmd_ready = 1'b0; dbus_rsp_valid = 1'b0;
        chk("completed", 64'(got), 64'd1);
        if (got) begin
            exp_lat = !obs_cmd ? 0 : obs_we ? hs_cyc + 1 : no_rsp ? hs_cyc + 1 + T : rsp_cyc + 1;
            chk("latency", 64'(cyc), 64'(exp_lat));
            chk("echo_instr", 64'(o_instr), 64'(instr));
            chk("echo_pc", 64'(o_pc), 64'(pc));
            chk("echo_op", 64'(o_op), 64'(op));
        end
        if (obs_cmd) chk("cmd_stable", 64'(stable), 64'd1);
    endtask

    task automatic check_exp(input string name, input logic [4:0] op, input logic [31:0] addr,
                             input logic [1:0] fault, input logic [31:0] val, input bit cmd,
                             input logic [3:0] strb, input logic [31:0] wdata);
        chk({name, "_fault"}, 64'(obs_fault), 64'(fault));
        chk({name, "_val"}, 64'(obs_val), 64'(val));
        chk({name, "_cmd"}, 64'(obs_cmd), 64'(cmd));
        if (cmd && obs_cmd) begin
            chk({name, "_strb"}, 64'(obs_strb), 64'(strb));
            chk({name, "_wdata"}, 64'(obs_wdata), 64'(wdata));
            chk({name, "_we"}, 64'(obs_we), 64'(op == OP_ST));
            chk({name, "_addr"}, 64'(obs_addr), 64'(addr));
        end
    endtask

    function automatic logic all_out_or();
        return |{t_instr_ready, i_instr, i_instr_valid, oPC, oDecodedOP, maAluValue, oFault,
                 dbus_cmd_addr, dbus_cmd_data, dbus_cmd_we, dbus_cmd_size, dbus_cmd_valid};
    endfunction

    initial begin
        vec_t        tbl[11];
        logic [1:0]  ef;
        logic [31:0] ev;
        bit          ec;
        logic [3:0]  es;
        logic [31:0] ew;
        logic [4:0]  rop;
        logic [2:0]  rf3;
        logic [31:0] raddr;
        logic [31:0] rrs2;
        logic [31:0] rrsp;

        tbl[0]  = '{"add",     OP_ALU, 3'd0, 32'h1234, 32'h0,        32'h0,        0, 0, 2'd0, 32'h1234,     1'b0, 4'h0, 32'h0};
        tbl[1]  = '{"sb",      OP_ST,  3'd0, 32'h1003, 32'hAB,       32'h0,        3, 0, 2'd0, 32'h1003,     1'b1, 4'h8, 32'hAB00_0000};
        tbl[2]  = '{"lb",      OP_LD,  3'd0, 32'h1002, 32'h0,        32'h0080_0000, 1, 0, 2'd0, 32'hFFFF_FF80, 1'b1, 4'h4, 32'h0};
        tbl[3]  = '{"lbu",     OP_LD,  3'd4, 32'h1002, 32'h0,        32'h0080_0000, 0, 1, 2'd0, 32'h0000_0080, 1'b1, 4'h4, 32'h0};
        tbl[4]  = '{"lhu",     OP_LD,  3'd5, 32'h1002, 32'h0,        32'hBEEF_0000, 0, 0, 2'd0, 32'h0000_BEEF, 1'b1, 4'hC, 32'h0};
        tbl[5]  = '{"lw_mis",  OP_LD,  3'd2, 32'h1001, 32'h0,        32'h0,        0, 0, 2'd1, 32'h1001,     1'b0, 4'h0, 32'h0};
        tbl[6]  = '{"sh_mis",  OP_ST,  3'd1, 32'h1003, 32'h1234,     32'h0,        0, 0, 2'd2, 32'h1003,     1'b0, 4'h0, 32'h0};
        tbl[7]  = '{"lh",      OP_LD,  3'd1, 32'h2000, 32'h0,        32'h0000_8001, 0, 2, 2'd0, 32'hFFFF_8001, 1'b1, 4'h3, 32'h0};
        tbl[8]  = '{"sw",      OP_ST,  3'd2, 32'h3000, 32'hDEAD_BEEF, 32'h0,       1, 0, 2'd0, 32'h3000,     1'b1, 4'hF, 32'hDEAD_BEEF};
        tbl[9]  = '{"ld_as_w", OP_LD,  3'd3, 32'h4004, 32'h0,        32'h8000_0000, 0, 0, 2'd0, 32'h8000_0000, 1'b1, 4'hF, 32'h0};
        tbl[10] = '{"sh",      OP_ST,  3'd1, 32'h1002, 32'hFFFF_1234, 32'h0,       0, 0, 2'd0, 32'h1002,     1'b1, 4'hC, 32'h1234_0000};

        #1 rstf = 1'b0;
        #2 chk("reset_outputs_zero", 64'(all_out_or()), 64'd0);
        @(negedge clk); rstf = 1'b1;
        #1 chk("ready_low_before_clock", 64'(t_instr_ready), 64'd0);
        @(posedge clk); #1;
        chk("ready_after_reset", 64'(t_instr_ready), 64'd1);

        for (int i = 0; i < 11; i++) begin
            run_op(tbl[i].op, tbl[i].f3, tbl[i].addr, tbl[i].rs2, tbl[i].rsp,
                   tbl[i].cmd_dly, tbl[i].rsp_dly, 1'b0, 1'b0);
            check_exp(tbl[i].name, tbl[i].op, tbl[i].addr, tbl[i].fault, tbl[i].val,
                      tbl[i].cmd, tbl[i].strb, tbl[i].wdata);
        end

        // Back-to-back ALU ops, one completion per cycle.
        iDecodedOP = OP_ALU;
        for (int k = 0; k < 4; k++) begin
            aluValue = 32'h100 + 32'(k); t_instr_valid = 1'b1;
            @(posedge clk); #1;
            chk("b2b_valid", 64'(i_instr_valid), 64'd1);
            chk("b2b_val", 64'(maAluValue), 64'(32'h100 + 32'(k)));
        end
        t_instr_valid = 1'b0;
        @(posedge clk); #1;

        // Downstream stall: outputs hold, no new accept.
        i_instr_ready = 1'b0; aluValue = 32'hA5A5; t_instr_valid = 1'b1;
        @(posedge clk); #1;
        aluValue = 32'h5A5A;
        for (int k = 0; k < 5; k++) begin
            chk("stall_ready", 64'(t_instr_ready), 64'd0);
            chk("stall_valid", 64'(i_instr_valid), 64'd1);
            chk("stall_val", 64'(maAluValue), 64'h A5A5);
            @(posedge clk); #1;
        end
        i_instr_ready = 1'b1;
        #1 chk("stall_release_ready", 64'(t_instr_ready), 64'd1);
        @(posedge clk); #1;
        t_instr_valid = 1'b0;
        chk("stall_next_val", 64'(maAluValue), 64'h5A5A);
        @(posedge clk); #1;
        chk("drain_clears_valid", 64'(i_instr_valid), 64'd0);

        // Timeout, then a stray response while idle is eaten, then a normal load.
        run_op(OP_LD, 3'd2, 32'h5000, 32'h0, 32'h0, 0, 0, 1'b1, 1'b0);
        check_exp("timeout1", OP_LD, 32'h5000, 2'd3, 32'h5000, 1'b1, 4'hF, 32'h0);
        dbus_rsp_valid = 1'b1; dbus_rsp_data = 32'h1111_1111;
        @(posedge clk); #1;
        dbus_rsp_valid = 1'b0;
        run_op(OP_LD, 3'd2, 32'h5004, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b0, 1'b0);
        check_exp("after_idle_drop", OP_LD, 32'h5004, 2'd0, 32'hCAFE_F00D, 1'b1, 4'hF, 32'h0);

        // Timeout, then the stale response lands during the next load and is discarded.
        run_op(OP_LD, 3'd2, 32'h6000, 32'h0, 32'h0, 1, 0, 1'b1, 1'b0);
        check_exp("timeout2", OP_LD, 32'h6000, 2'd3, 32'h6000, 1'b1, 4'hF, 32'h0);
        run_op(OP_LD, 3'd2, 32'h6008, 32'h0, 32'h1357_9BDF, 0, 2, 1'b0, 1'b1);
        check_exp("after_rsp_drop", OP_LD, 32'h6008, 2'd0, 32'h1357_9BDF, 1'b1, 4'hF, 32'h0);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 40; k++) begin
            rop   = 5'($urandom_range(0, 2));
            rf3   = 3'($urandom_range(0, 6));
            raddr = $urandom;
            if ($urandom_range(0, 2) != 0) raddr[1:0] = 2'b00;
            rrs2  = $urandom;
            rrsp  = $urandom;
            model(rop, rf3, raddr, rrs2, rrsp, ef, ev, ec, es, ew);
            run_op(rop, rf3, raddr, rrs2, rrsp, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b0);
            check_exp("rand", rop, raddr, ef, ev, ec, es, ew);
        end

        // Reset while a store command is outstanding.
        t_instr = 32'h0000_2023; iDecodedOP = OP_ST; aluValue = 32'h7000; rs2Value = 32'h55; t_instr_valid = 1'b1;
        @(posedge clk); #1;
        t_instr_valid = 1'b0;
        chk("cmd_before_reset", 64'(dbus_cmd_valid), 64'd1);
        #2 rstf = 1'b0;
        #1 chk("midcmd_reset_zero", 64'(all_out_or()), 64'd0);
        @(negedge clk); rstf = 1'b1;
        run_op(OP_ALU, 3'd0, 32'h9999, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0);
        check_exp("post_reset_add", OP_ALU, 32'h9999, 2'd0, 32'h9999, 1'b0, 4'h0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
